// File: rtl/serial_adder_sched.sv
// serial_adder_sched
//   Bit-serial add scheduler. Two requesters share one full-adder cell.
//   Each accepted request produces a WIDTH-bit sum and a carry-out. The sum
//   is computed LSB-first over WIDTH cycles, and the carry is held in a flop
//   between cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/ready      request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b        operands, sampled only on the transfer edge
//   reqN_cin              carry-in
//   res_valid/ready       result handshake
//   res_sum, res_cout     a + b + cin (low WIDTH bits) and the carry out of bit WIDTH-1
//   res_id                requester that owns the result

// Single full-adder cell shared by both requesters.
module serial_adder_sched_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] sa, sb, ss;
    logic            c;
    logic [CW-1:0]   cnt;
    logic            ptr;
    logic            id;
    logic            fa_sum, fa_cout;
    logic            grant0, grant1;
    logic            last;
    logic            take;

    serial_adder_sched_fa u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // When both requesters are valid, ptr selects the winner.
    assign grant0 = req0_valid & (~req1_valid | ~ptr);
    assign grant1 = req1_valid & (~req0_valid |  ptr);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign take   = req0_ready | req1_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take)      state_nx = ADD;
            ADD:     if (last)      state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Output logic. rst_n is gated in so that both readies stay low
    // throughout reset, even though the state register already reads IDLE.
    always_comb begin
        req0_ready = rst_n & (state == IDLE) & grant0;
        req1_ready = rst_n & (state == IDLE) & grant1;
        res_valid  = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            ss       <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            ptr      <= 1'b0;
            id       <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
            res_id   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        sa  <= req1_ready ? req1_a   : req0_a;
                        sb  <= req1_ready ? req1_b   : req0_b;
                        c   <= req1_ready ? req1_cin : req0_cin;
                        cnt <= '0;
                        id  <= req1_ready;
                        ptr <= ~req1_ready;
                    end
                end
                ADD: begin
                    ss  <= {fa_sum, ss[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= fa_cout;
                    cnt <= cnt + CW'(1);
                    // Capture the result directly from the last shift, so it
                    // is already valid in the first DONE cycle.
                    if (last) begin
                        res_sum  <= {fa_sum, ss[WIDTH-1:1]};
                        res_cout <= fa_cout;
                        res_id   <= id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_sched.sv
module tb_serial_adder_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0v[2], r1v[2], rr[2];
    logic       r0r[2], r1r[2], rv[2];
    logic [7:0] a0[2], b0[2], a1[2], b1[2];
    logic       c0[2], c1[2];
    int         acc[2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d]: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int W = (k == 0) ? 8 : 3;
        logic [W-1:0] sum_o;
        logic         cout_o, id_o;

        serial_adder_sched #(.WIDTH(W)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (r0v[k]),
            .req0_ready (r0r[k]),
            .req0_a     (a0[k][W-1:0]),
            .req0_b     (b0[k][W-1:0]),
            .req0_cin   (c0[k]),
            .req1_valid (r1v[k]),
            .req1_ready (r1r[k]),
            .req1_a     (a1[k][W-1:0]),
            .req1_b     (b1[k][W-1:0]),
            .req1_cin   (c1[k]),
            .res_valid  (rv[k]),
            .res_ready  (rr[k]),
            .res_sum    (sum_o),
            .res_cout   (cout_o),
            .res_id     (id_o)
        );

        // Transaction-level model: 'busy' counts down the remaining serial
        // cycles, 'mval' marks a pending result, and osum/oc/oid are the
        // result registers as seen by the consumer.
        int           busy;
        bit           mval, mptr, midle, mg0, mg1;
        logic [W-1:0] psum, osum;
        logic         pc, oc, pid, oid;
        logic [W:0]   t;

        always @(negedge clk) begin
            if (!rst_n) begin
                busy = 0; mval = 0; mptr = 0;
                osum = '0; oc = 1'b0; oid = 1'b0;
                chk("rst_ready0", k, 32'(r0r[k]), 0);
                chk("rst_ready1", k, 32'(r1r[k]), 0);
                chk("rst_res_valid", k, 32'(rv[k]), 0);
                chk("rst_res_sum", k, 32'(sum_o), 0);
            end else begin
                midle = !mval && (busy == 0);
                mg0   = r0v[k] && (!r1v[k] || !mptr);
                mg1   = r1v[k] && (!r0v[k] ||  mptr);
                chk("ready0", k, 32'(r0r[k]), 32'(midle && mg0));
                chk("ready1", k, 32'(r1r[k]), 32'(midle && mg1));
                chk("res_valid", k, 32'(rv[k]), 32'(mval));
                chk("res_sum", k, 32'(sum_o), 32'(osum));
                chk("res_cout", k, 32'(cout_o), 32'(oc));
                chk("res_id", k, 32'(id_o), 32'(oid));
                if (mval) begin
                    if (rr[k]) mval = 0;
                end else if (busy > 0) begin
                    busy--;
                    if (busy == 0) begin
                        mval = 1; osum = psum; oc = pc; oid = pid;
                    end
                end else if (mg0 || mg1) begin
                    pid = mg1;
                    if (mg1) t = {1'b0, a1[k][W-1:0]} + {1'b0, b1[k][W-1:0]} + {{W{1'b0}}, c1[k]};
                    else     t = {1'b0, a0[k][W-1:0]} + {1'b0, b0[k][W-1:0]} + {{W{1'b0}}, c0[k]};
                    psum = t[W-1:0];
                    pc   = t[W];
                    busy = W;
                    mptr = !mg1;
                    acc[k]++;
                end
            end
        end
    end

    // One request on instance 0, checked against hand-computed literals.
    task automatic do_req(input bit id, input logic [7:0] a, input logic [7:0] b, input bit cin,
                          input logic [7:0] es, input bit ec, input bit eid);
        int n;
        @(posedge clk); #1;
        if (id) begin r1v[0] = 1; a1[0] = a; b1[0] = b; c1[0] = cin; end
        else    begin r0v[0] = 1; a0[0] = a; b0[0] = b; c0[0] = cin; end
        n = 0;
        @(negedge clk);
        while (!(id ? r1r[0] : r0r[0]) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready never rose, expected within 50 cycles");
        end
        @(posedge clk); #1;
        r0v[0] = 0; r1v[0] = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rv[0] && n < 50);
        chk("latency", 0, n, 9);
        chk("lit_sum", 0, 32'(g[0].sum_o), 32'(es));
        chk("lit_cout", 0, 32'(g[0].cout_o), 32'(ec));
        chk("lit_id", 0, 32'(g[0].id_o), 32'(eid));
    endtask

    initial begin
        int   acc_cyc[$];
        bit   acc_id[$];
        logic [7:0] rsum[$];
        bit   rid[$];
        int   n;

        for (int k = 0; k < 2; k++) begin
            r0v[k] = 0; r1v[k] = 0; rr[k] = 1;
            a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0; c0[k] = 0; c1[k] = 0;
            acc[k] = 0;
        end

        // Fairness: both requesters are valid from reset.
        r0v[0] = 1; a0[0] = 8'h10; b0[0] = 8'h20;
        r1v[0] = 1; a1[0] = 8'h01; b1[0] = 8'h02;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (r0r[0] || r1r[0]) begin acc_cyc.push_back(i); acc_id.push_back(r1r[0]); end
            if (rv[0]) begin rsum.push_back(g[0].sum_o); rid.push_back(g[0].id_o); end
        end
        @(posedge clk); #1;
        r0v[0] = 0; r1v[0] = 0;
        chk("fair_accepts", 0, 32'(acc_cyc.size() >= 4), 1);
        chk("fair_results", 0, 32'(rsum.size() >= 2), 1);
        if (acc_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("fair_id", 0, 32'(acc_id[i]), 32'(i % 2));
            for (int i = 0; i < 3; i++) chk("fair_spacing", 0, acc_cyc[i+1] - acc_cyc[i], 10);
        end
        if (rsum.size() >= 2) begin
            chk("fair_sum0", 0, 32'(rsum[0]), 32'h30);
            chk("fair_rid0", 0, 32'(rid[0]), 0);
            chk("fair_sum1", 0, 32'(rsum[1]), 32'h03);
            chk("fair_rid1", 0, 32'(rid[1]), 1);
        end
        repeat (15) @(posedge clk);

        // Single requests, including the carry corner cases.
        do_req(0, 8'hA5, 8'h3C, 0, 8'hE1, 0, 0);
        do_req(0, 8'hFF, 8'h01, 0, 8'h00, 1, 0);
        do_req(0, 8'h00, 8'h00, 1, 8'h01, 0, 0);
        do_req(0, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0);
        do_req(1, 8'h80, 8'h80, 0, 8'h00, 1, 1);

        // Backpressure: the result must hold and no request may be accepted.
        @(posedge clk); #1 rr[0] = 0;
        do_req(0, 8'h12, 8'h34, 0, 8'h46, 0, 0);
        @(posedge clk); #1;
        r1v[0] = 1; a1[0] = 8'h05; b1[0] = 8'h06; c1[0] = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 0, 32'(rv[0]), 1);
            chk("bp_sum", 0, 32'(g[0].sum_o), 32'h46);
            chk("bp_id", 0, 32'(g[0].id_o), 0);
            chk("bp_ready0", 0, 32'(r0r[0]), 0);
            chk("bp_ready1", 0, 32'(r1r[0]), 0);
        end
        @(posedge clk); #1 rr[0] = 1;
        @(negedge clk);
        chk("bp_handshake_ready1", 0, 32'(r1r[0]), 0);
        @(negedge clk);
        chk("bp_idle_ready1", 0, 32'(r1r[0]), 1);
        @(posedge clk); #1 r1v[0] = 0;
        repeat (12) @(posedge clk);

        // Reset 4 cycles into ADD.
        @(posedge clk); #1;
        r0v[0] = 1; a0[0] = 8'h11; b0[0] = 8'h22; c0[0] = 0;
        n = 0;
        @(negedge clk);
        while (!r0r[0] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 r0v[0] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        r1v[0] = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_ready0", 0, 32'(r0r[0]), 0);
            chk("mid_rst_ready1", 0, 32'(r1r[0]), 0);
            chk("mid_rst_valid", 0, 32'(rv[0]), 0);
        end
        @(posedge clk); #1;
        rst_n = 1; r1v[0] = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_no_result", 0, 32'(rv[0]), 0);
        end
        do_req(0, 8'h7F, 8'h01, 0, 8'h80, 0, 0);
        repeat (3) @(posedge clk);

        // Random traffic with backpressure on both widths.
        acc[0] = 0; acc[1] = 0;
        n = 0;
        while ((acc[0] < 1000 || acc[1] < 1000) && n < 40000) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                r0v[k] = ($urandom_range(9) < 6);
                r1v[k] = ($urandom_range(9) < 6);
                a0[k] = 8'($urandom); b0[k] = 8'($urandom); c0[k] = 1'($urandom);
                a1[k] = 8'($urandom); b1[k] = 8'($urandom); c1[k] = 1'($urandom);
                rr[k] = ($urandom_range(9) < 7);
            end
            n++;
        end
        if (n >= 40000) begin
            checks++; errors++;
            $display("FAIL random_budget: accepts %0d/%0d, required 1000 each", acc[0], acc[1]);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin r0v[k] = 0; r1v[k] = 0; rr[k] = 1; end
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_sched.md
# serial_adder_sched

Bit-serial add scheduler that time-shares a single ADDER full-adder cell between two requesters. Each accepted request gives a WIDTH-bit sum and a carry-out, computed LSB-first over WIDTH cycles. The carry is held in a flip-flop between cycles. It sits between two operand producers and one result consumer where area matters more than throughput.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid  in  1  requester 0 operands valid
- req0_ready  out  1  requester 0 accepted this cycle (valid&ready = transfer)
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  WIDTH  a + b + cin, low WIDTH bits
- res_cout  out  1  carry out of bit WIDTH-1
- res_id  out  1  requester that owns the result

## Operation
- One clock; reset is asynchronous and active-low.
- Datapath:
  - shift registers sa, sb (WIDTH);
  - sum register ss (WIDTH);
  - carry flop c;
  - bit counter cnt (clog2(WIDTH+1) bits);
  - priority pointer ptr (1 bit);
  - one ADDER instance with a=sa[0], b=sb[0], cin=c.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - Grant rules:
    - If only one req valid, grant it.
    - If both are valid, grant req[ptr].
  - reqN_ready = (state==IDLE) & grantN, combinational; it is never high for both requesters.
  - On transfer: load sa/sb from the operands, c=cin, cnt=0, latch id, ptr = ~id. Go to ADD.
- ADD, each cycle:
  - ss = {sum, ss[WIDTH-1:1]};
  - sa, sb shift right by 1;
  - c = cout;
  - cnt++.
  - When cnt reaches WIDTH-1 (last bit), go to DONE.
- Entering DONE:
  - res_sum = ss after the final shift;
  - res_cout = final cout;
  - res_id = latched id.
- DONE:
  - res_valid=1.
  - Hold until res_ready=1, then go to IDLE.
  - No new request is accepted in the DONE state, including the handshake cycle.
- res_sum, res_cout and res_id are registered. They stay stable while res_valid=1 and hold their last value otherwise.
- Arithmetic is unsigned modulo 2^WIDTH. The carry-out is the true bit WIDTH of a+b+cin.

## Timing
- Reset values:
  - state=IDLE, ptr=0;
  - res_valid=0, res_sum=0, res_cout=0, res_id=0;
  - internal registers 0.
- While rst_n=0: req0_ready=req1_ready=0.
- Request accepted on edge T:
  - ADD occupies cycles T+1..T+WIDTH.
  - res_valid=1 from cycle T+WIDTH+1.
- With res_ready held high, a result is consumed in its first valid cycle. The next accept is possible one cycle later, giving one operation per WIDTH+2 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… starting with 0 after reset.
- A requester deasserting valid while not granted is legal and loses nothing. Operands are sampled only on the transfer edge.
- Reset mid-ADD or mid-DONE:
  - The operation is discarded and no result is issued.
  - res_valid drops immediately (asynchronously).
  - ptr returns to 0.
- res_ready while res_valid=0 is ignored.

## Test plan
- WIDTH=8, req0 a=0xA5 b=0x3C cin=0 accepted at cycle T → res_valid at T+9, res_sum=0xE1, res_cout=0, res_id=0.
- Carry cases, one at a time:
  - 0xFF+0x01 cin=0 → sum 0x00, cout 1;
  - 0x00+0x00 cin=1 → 0x01, cout 0;
  - 0xFF+0xFF cin=1 → 0xFF, cout 1.
- Both requesters valid from reset with distinct operands (req0 0x10+0x20, req1 0x01+0x02), res_ready=1 → results in order id0 (0x30), then id1 (0x03). Four back-to-back requests alternate ids 0,1,0,1. Accepts are spaced 10 cycles apart.
- res_ready=0 for 5 cycles after res_valid → res_valid, res_sum and res_id stay constant, and both readies stay 0. One cycle after res_ready=1 the FSM is back in IDLE and accepts.
- rst_n pulsed low 4 cycles into ADD → no res_valid, readies 0 during reset. The next request (0x7F+0x01) yields 0x80, cout 0, id 0.
- 1000 random requests with random valids and backpressure, WIDTH=8 and WIDTH=3 → every result equals a+b+cin and matches its requester id. No request is lost or duplicated.
